// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Time-multiplexed driver for a NUM_DIGITS-digit seven-segment display.
//   Scans one digit per slot of SCAN_DIV clocks. It takes a frame-coherent
//   snapshot of the inputs and supports per-digit enable, leading-zero
//   blanking, per-digit blink, a dead time at the start of each slot, and
//   configurable segment and digit polarity.
//
// Ports
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   digits     in   packed hex nibbles; nibble k = digits[4k+3:4k], k=0 is LSD
//   digit_en   in   1 = digit k may light
//   blank_lz   in   1 = suppress leading zeros (sampled live, not snapshotted)
//   blink_mask in   1 = digit k blinks
//   seg_out    out  {g,f,e,d,c,b,a}, after polarity
//   dig_sel    out  one-hot digit strobe, after polarity
//   frame_tick out  1-cycle pulse marking the start of a new displayed frame

module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 0,
    parameter int DIG_ACT_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic DIG_INV = (DIG_ACT_LOW != 0);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [FW-1:0]           fcnt;
    logic                    blink_ph;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    snap_q;

    logic                    tick;
    logic                    snap;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    all_zero;
    logic [3:0]              cur_nib;
    logic                    visible;
    logic                    in_dead;
    logic [6:0]              raw_seg;
    logic [NUM_DIGITS-1:0]   raw_dig;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tick = (pcnt == PW'(SCAN_DIV - 1));
    assign snap = tick && (idx == IW'(NUM_DIGITS - 1));

    // Scan counters, frame counter and input snapshot
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pcnt      <= '0;
            idx       <= '0;
            fcnt      <= '0;
            blink_ph  <= 1'b0;
            sh_digits <= '0;
            sh_en     <= '0;
            sh_blink  <= '0;
            snap_q    <= 1'b0;
        end else begin
            pcnt   <= tick ? '0 : pcnt + 1'b1;
            snap_q <= snap;
            if (tick) begin
                idx <= snap ? '0 : idx + 1'b1;
            end
            if (snap) begin
                sh_digits <= digits;
                sh_en     <= digit_en;
                sh_blink  <= blink_mask;
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt     <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Leading-zero blanking: walk down from the top digit while every nibble
    // seen so far is zero. Digit 0 is never blanked.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
            all_zero = all_zero & (sh_digits[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            lz_blank[NUM_DIGITS-1-i] = blank_lz & all_zero;
        end
    end

    always_comb begin
        cur_nib = sh_digits[4*idx +: 4];
        visible = sh_en[idx] & ~(sh_blink[idx] & blink_ph) & ~lz_blank[idx];
        in_dead = (int'(pcnt) < DEAD);
        raw_dig = '0;
        raw_seg = '0;
        if (!in_dead) begin
            raw_dig = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
            if (visible) begin
                raw_seg = enc(cur_nib);
            end
        end
    end

    // Output stage; frame_tick rides the same register stage as the strobes
    // so it lines up with the first output cycle of the new frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seg_out    <= {7{SEG_INV}};
            dig_sel    <= {NUM_DIGITS{DIG_INV}};
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= raw_seg ^ {7{SEG_INV}};
            dig_sel    <= raw_dig ^ {NUM_DIGITS{DIG_INV}};
            frame_tick <= snap_q;
        end
    end

endmodule
